// File: rtl/aes_uart_cmd_ctrl.sv
// aes_uart_cmd_ctrl: decodes UART command frames, drives the AES key/text/load
// interface and queues reply frames for UART TX.
module aes_uart_cmd_ctrl #(
    parameter int FRAME_BYTES    = 18,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int ERR_W          = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     frame_valid,
    input  logic [8*FRAME_BYTES-1:0] frame_data,
    output logic [127:0]             aes_key,
    output logic [127:0]             aes_text,
    output logic                     aes_ld,
    input  logic                     aes_done,
    input  logic [127:0]             aes_result,
    output logic [8*FRAME_BYTES-1:0] tx_data,
    output logic                     tx_send,
    input  logic                     tx_busy,
    output logic                     busy,
    output logic [ERR_W-1:0]         err_count
);
    localparam int FW = 8*FRAME_BYTES;
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [7:0] OP_C = 8'h43, OP_D = 8'h44, OP_E = 8'h45, OP_R = 8'h52;
    localparam logic [7:0] OP_AT = 8'h40, OP_LA = 8'h61, OP_LB = 8'h62, OP_A = 8'h41, OP_BANG = 8'h21;
    localparam logic [127:0] ID_STR = 128'h31323334353637383930313233343536;

    typedef enum logic [2:0] {IDLE, DECODE, AES_START, AES_WAIT, TX_WAIT, TX_SEND} state_t;
    state_t state, next;

    logic [FW-1:0]  frame_reg;
    logic [127:0]   result_reg;
    logic [CW-1:0]  tmo_cnt;
    logic [7:0]     op_hi, op_lo;
    logic [127:0]   payload, reply_val;
    logic           op_ok, is_reply, is_r, done, tmo, reject, drop;
    logic [ERR_W:0] err_sum;

    assign op_hi     = frame_reg[FW-1 -: 8];
    assign op_lo     = frame_reg[7:0];
    assign payload   = frame_reg[FW-9:8];
    assign is_reply  = op_lo inside {OP_AT, OP_LA, OP_LB, OP_A};
    assign op_ok     = (op_hi == op_lo) && (is_reply || (op_lo inside {OP_C, OP_D, OP_E, OP_R}));
    assign is_r      = op_lo == OP_R;
    assign reply_val = op_lo == OP_AT ? result_reg :
                       op_lo == OP_LA ? aes_key :
                       op_lo == OP_LB ? aes_text : ID_STR;
    // tmo_cnt==0 marks the first wait cycle, where aes_done may still be a stale level
    assign done      = state == AES_WAIT && tmo_cnt != '0 && aes_done;
    assign tmo       = state == AES_WAIT && !done && tmo_cnt == CW'(TIMEOUT_CYCLES-1);
    assign reject    = state == DECODE && !op_ok;
    assign drop      = frame_valid && state != IDLE;
    assign err_sum   = {1'b0, err_count} + (ERR_W+1)'(drop) + (ERR_W+1)'(reject | tmo);
    assign aes_ld    = state == AES_START;
    assign tx_send   = state == TX_SEND && !tx_busy;
    assign busy      = state != IDLE;

    always_comb begin
        next = state;
        case (state)
            IDLE:      next = frame_valid ? DECODE : IDLE;
            DECODE:    next = !op_ok ? IDLE :
                              (op_lo == OP_E || is_r) ? AES_START :
                              is_reply ? TX_WAIT : IDLE;
            AES_START: next = AES_WAIT;
            AES_WAIT:  next = (done || tmo) ? (is_r ? TX_WAIT : IDLE) : AES_WAIT;
            TX_WAIT:   next = tx_busy ? TX_WAIT : TX_SEND;
            TX_SEND:   next = tx_busy ? TX_WAIT : IDLE;
            default:   next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            frame_reg  <= '0;
            aes_key    <= '0;
            aes_text   <= '0;
            result_reg <= '0;
            tx_data    <= '0;
            tmo_cnt    <= '0;
            err_count  <= '0;
        end else begin
            state     <= next;
            err_count <= err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
            tmo_cnt   <= state == AES_WAIT ? tmo_cnt + 1'b1 : '0;
            if (state == IDLE && frame_valid)
                frame_reg <= frame_data;
            if (state == DECODE && op_ok && op_lo == OP_C)
                aes_key <= payload;
            if (state == DECODE && op_ok && op_lo == OP_D)
                aes_text <= payload;
            if (state == DECODE && op_ok && is_reply)
                tx_data <= {op_lo, reply_val, op_lo};
            if (done)
                result_reg <= aes_result;
            if ((done || tmo) && is_r)
                tx_data <= done ? {OP_AT, aes_result, OP_AT} : {OP_BANG, 128'h0, OP_BANG};
        end
    end
endmodule

// File: tb/tb_aes_uart_cmd_ctrl.sv
// tb_aes_uart_cmd_ctrl: randomized command traffic against a frame-level
// reference model, with a behavioural AES responder.
module tb_aes_uart_cmd_ctrl;
    logic         clk = 0, reset = 1, frame_valid = 0, aes_done = 0, tx_busy = 0;
    logic [143:0] frame_data = '0, tx_data;
    logic [127:0] aes_key, aes_text, aes_result = '0;
    logic         aes_ld, tx_send, busy;
    logic [7:0]   err_count;

    aes_uart_cmd_ctrl dut (
        .clk(clk), .reset(reset), .frame_valid(frame_valid), .frame_data(frame_data),
        .aes_key(aes_key), .aes_text(aes_text), .aes_ld(aes_ld), .aes_done(aes_done),
        .aes_result(aes_result), .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy),
        .busy(busy), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int ld_cnt = 0, send_cnt = 0;
    logic [143:0] tx_q[$];
    bit   resp_en = 1;
    int   resp_dly = 2;
    logic [127:0] last_ct = '0;
    logic [127:0] m_key = '0, m_text = '0, m_res = '0;
    int   m_err = 0;

    localparam logic [7:0] C_ = "C", D_ = "D", E_ = "E", R_ = "R", AT = "@", LA = "a", LB = "b", A_ = "A", BANG = "!";

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (aes_ld) ld_cnt++;
        if (tx_send) begin
            send_cnt++;
            tx_q.push_back(tx_data);
            total++;
            if (tx_busy) begin
                bad++;
                $display("FAIL tx_send_while_busy: tx_send=1 with tx_busy=%0b (required tx_busy=0)", tx_busy);
            end
        end
    end

    // Behavioural AES core: holds aes_done as a level until the next load,
    // so the previous result is still asserted in the first wait cycle.
    initial forever begin
        @(negedge clk);
        if (aes_ld) begin
            tick();
            tick();
            aes_done = 0;
            if (resp_en) begin
                repeat (resp_dly) tick();
                last_ct = rnd128();
                aes_result = last_ct;
                aes_done = 1;
            end
        end
    end

    task automatic model_reset();
        m_key = '0; m_text = '0; m_res = '0; m_err = 0;
        tx_q.delete();
    endtask

    task automatic model_cmd(input logic [7:0] hi, input logic [7:0] lo, input logic [127:0] p,
                             output bit rep, output logic [143:0] exp, output int lds);
        rep = 0; exp = '0; lds = 0;
        if (hi !== lo) m_err = m_err < 255 ? m_err + 1 : 255;
        else if (lo == C_) m_key = p;
        else if (lo == D_) m_text = p;
        else if (lo == E_) begin lds = 1; m_res = last_ct; end
        else if (lo == R_) begin lds = 1; m_res = last_ct; rep = 1; exp = {AT, last_ct, AT}; end
        else if (lo == AT) begin rep = 1; exp = {AT, m_res, AT}; end
        else if (lo == LA) begin rep = 1; exp = {LA, m_key, LA}; end
        else if (lo == LB) begin rep = 1; exp = {LB, m_text, LB}; end
        else if (lo == A_) begin rep = 1; exp = {A_, 128'h31323334353637383930313233343536, A_}; end
        else m_err = m_err < 255 ? m_err + 1 : 255;
    endtask

    task automatic send_frame(input logic [7:0] hi, input logic [7:0] lo, input logic [127:0] p);
        tick();
        frame_valid = 1;
        frame_data = {hi, p, lo};
        tick();
        frame_valid = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 500) begin
            tick();
            n++;
            if (n == 5) tx_busy = 0;
        end
        total++;
        if (busy) begin
            bad++;
            $display("FAIL wait_idle: busy=%0b after %0d cycles (required 0)", busy, n);
        end
    endtask

    task automatic do_cmd(input logic [7:0] hi, input logic [7:0] lo, input logic [127:0] p);
        send_frame(hi, lo, p);
        wait_idle();
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (3) tick();
        reset = 0;
        tick();
        model_reset();
        total += 4;
        if (aes_key !== '0 || aes_text !== '0) begin bad++; $display("FAIL reset_regs: key=%h text=%h (required 0)", aes_key, aes_text); end
        if (tx_data !== '0) begin bad++; $display("FAIL reset_tx_data: %h (required 0)", tx_data); end
        if ({aes_ld, tx_send, busy} !== 3'b000) begin bad++; $display("FAIL reset_strobes: ld/send/busy=%b (required 000)", {aes_ld, tx_send, busy}); end
        if (err_count !== 8'h00) begin bad++; $display("FAIL reset_err: %0d (required 0)", err_count); end
    endtask

    task automatic test_set_key();
        logic [127:0] k = 128'h000102030405060708090a0b0c0d0e0f;
        int s0 = send_cnt;
        send_frame(C_, C_, k);
        total += 4;
        if (aes_key !== '0) begin bad++; $display("FAIL set_key_early: key=%h (required 0 at frame+1)", aes_key); end
        tick();
        m_key = k;
        if (aes_key !== k) begin bad++; $display("FAIL set_key: key=%h (required %h)", aes_key, k); end
        wait_idle();
        if (send_cnt !== s0) begin bad++; $display("FAIL set_key_nosend: sends=%0d (required %0d)", send_cnt, s0); end
        if (err_count !== 8'd0) begin bad++; $display("FAIL set_key_err: %0d (required 0)", err_count); end
    endtask

    task automatic test_mismatch();
        int l0 = ld_cnt;
        do_cmd(E_, A_, rnd128());
        m_err++;
        total += 3;
        if (err_count !== 8'(m_err)) begin bad++; $display("FAIL mismatch_err: %0d (required %0d)", err_count, m_err); end
        if (aes_key !== m_key || aes_text !== m_text) begin bad++; $display("FAIL mismatch_regs: key=%h text=%h (required %h %h)", aes_key, aes_text, m_key, m_text); end
        if (ld_cnt !== l0) begin bad++; $display("FAIL mismatch_ld: loads=%0d (required %0d)", ld_cnt, l0); end
    endtask

    task automatic test_encrypt();
        logic [143:0] got;
        int l0;
        m_key = rnd128();
        m_text = rnd128();
        do_cmd(C_, C_, m_key);
        do_cmd(D_, D_, m_text);
        l0 = ld_cnt;
        do_cmd(R_, R_, rnd128());
        m_res = last_ct;
        total += 4;
        if (ld_cnt !== l0 + 1) begin bad++; $display("FAIL encrypt_ld: loads=%0d (required %0d)", ld_cnt, l0 + 1); end
        if (aes_key !== m_key || aes_text !== m_text) begin bad++; $display("FAIL encrypt_regs: key=%h text=%h (required %h %h)", aes_key, aes_text, m_key, m_text); end
        if (tx_q.size() !== 1) begin bad++; $display("FAIL encrypt_sends: %0d (required 1)", tx_q.size()); end
        got = tx_q.size() > 0 ? tx_q.pop_front() : '0;
        if (got !== {AT, m_res, AT}) begin bad++; $display("FAIL encrypt_reply: %h (required %h)", got, {AT, m_res, AT}); end
        tx_q.delete();
    endtask

    task automatic test_timeout();
        logic [143:0] got;
        logic [7:0] e0 = err_count;
        int n = 0;
        resp_en = 0;
        tick();
        frame_valid = 1;
        frame_data = {R_, 128'h0, R_};
        tick();
        frame_valid = 0;
        n = 1;
        while (err_count === e0 && n < 200) begin tick(); n++; end
        wait_idle();
        resp_en = 1;
        m_err++;
        total += 4;
        if (n !== 67) begin bad++; $display("FAIL timeout_latency: err rose at cycle %0d (required 67)", n); end
        if (err_count !== 8'(m_err)) begin bad++; $display("FAIL timeout_err: %0d (required %0d)", err_count, m_err); end
        got = tx_q.size() > 0 ? tx_q.pop_front() : '0;
        if (got !== {BANG, 128'h0, BANG}) begin bad++; $display("FAIL timeout_reply: %h (required %h)", got, {BANG, 128'h0, BANG}); end
        do_cmd(AT, AT, '0);
        got = tx_q.size() > 0 ? tx_q.pop_front() : '0;
        if (got !== {AT, m_res, AT}) begin bad++; $display("FAIL timeout_result_kept: %h (required %h)", got, {AT, m_res, AT}); end
    endtask

    task automatic test_busy_defer();
        logic [143:0] got;
        int s0 = send_cnt;
        tx_busy = 1;
        send_frame(LA, LA, rnd128());
        repeat (10) tick();
        total += 4;
        if (send_cnt !== s0) begin bad++; $display("FAIL defer_held: sends=%0d (required %0d)", send_cnt, s0); end
        if (busy !== 1'b1) begin bad++; $display("FAIL defer_busy: busy=%0b (required 1)", busy); end
        tx_busy = 0;
        wait_idle();
        repeat (3) tick();
        if (send_cnt !== s0 + 1) begin bad++; $display("FAIL defer_once: sends=%0d (required %0d)", send_cnt, s0 + 1); end
        got = tx_q.size() > 0 ? tx_q.pop_front() : '0;
        if (got !== {LA, m_key, LA} || tx_data !== {LA, m_key, LA}) begin bad++; $display("FAIL defer_reply: sent=%h held=%h (required %h)", got, tx_data, {LA, m_key, LA}); end
    endtask

    task automatic test_drop();
        logic [143:0] got;
        resp_dly = 20;
        send_frame(R_, R_, '0);
        repeat (4) tick();
        send_frame(C_, C_, rnd128());
        wait_idle();
        resp_dly = 2;
        m_err++;
        m_res = last_ct;
        total += 3;
        if (err_count !== 8'(m_err)) begin bad++; $display("FAIL drop_err: %0d (required %0d)", err_count, m_err); end
        if (aes_key !== m_key) begin bad++; $display("FAIL drop_key: %h (required %h)", aes_key, m_key); end
        got = tx_q.size() > 0 ? tx_q.pop_front() : '0;
        if (got !== {AT, m_res, AT}) begin bad++; $display("FAIL drop_reply: %h (required %h)", got, {AT, m_res, AT}); end
    endtask

    task automatic test_reset_mid();
        int s0;
        tx_busy = 1;
        send_frame(LB, LB, '0);
        repeat (3) tick();
        reset = 1;
        tick();
        reset = 0;
        tx_busy = 0;
        s0 = send_cnt;
        repeat (10) tick();
        model_reset();
        total += 3;
        if (send_cnt !== s0) begin bad++; $display("FAIL reset_mid_send: sends=%0d (required %0d)", send_cnt, s0); end
        if (tx_data !== '0 || aes_key !== '0 || aes_text !== '0) begin bad++; $display("FAIL reset_mid_regs: tx=%h key=%h text=%h (required 0)", tx_data, aes_key, aes_text); end
        if (err_count !== 8'd0 || busy !== 1'b0) begin bad++; $display("FAIL reset_mid_state: err=%0d busy=%0b (required 0 0)", err_count, busy); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ops[9] = '{C_, D_, E_, R_, AT, LA, LB, A_, "Z"};
        logic [7:0] hi, lo;
        logic [127:0] p;
        logic [143:0] exp, got;
        bit rep;
        int lds, l0;
        for (int i = 0; i < 60; i++) begin
            lo = ops[$urandom_range(0, 8)];
            hi = ($urandom_range(0, 7) == 0) ? 8'($urandom) : lo;
            p = rnd128();
            resp_dly = $urandom_range(0, 5);
            tx_busy = $urandom_range(0, 2) == 0;
            l0 = ld_cnt;
            do_cmd(hi, lo, p);
            tx_busy = 0;
            repeat (2) tick();
            model_cmd(hi, lo, p, rep, exp, lds);
            total += 4;
            if (aes_key !== m_key || aes_text !== m_text) begin bad++; $display("FAIL rand_regs[%0d] op=%h/%h: key=%h text=%h (required %h %h)", i, hi, lo, aes_key, aes_text, m_key, m_text); end
            if (err_count !== 8'(m_err)) begin bad++; $display("FAIL rand_err[%0d] op=%h/%h: %0d (required %0d)", i, hi, lo, err_count, m_err); end
            if (ld_cnt - l0 !== lds) begin bad++; $display("FAIL rand_ld[%0d] op=%h/%h: %0d (required %0d)", i, hi, lo, ld_cnt - l0, lds); end
            if (tx_q.size() !== int'(rep)) begin bad++; $display("FAIL rand_sends[%0d] op=%h/%h: %0d (required %0d)", i, hi, lo, tx_q.size(), rep); end
            got = tx_q.size() > 0 ? tx_q.pop_front() : '0;
            if (rep && got !== exp) begin total++; bad++; $display("FAIL rand_reply[%0d] op=%h: %h (required %h)", i, lo, got, exp); end
            else if (rep) total++;
            tx_q.delete();
        end
        resp_dly = 2;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 300; i++) begin
            do_cmd(C_, D_, '0);
            m_err = m_err < 255 ? m_err + 1 : 255;
        end
        total += 2;
        if (err_count !== 8'hFF) begin bad++; $display("FAIL saturation: %h (required ff)", err_count); end
        if (aes_key !== m_key) begin bad++; $display("FAIL saturation_key: %h (required %h)", aes_key, m_key); end
    endtask

    initial begin
        test_reset();
        test_set_key();
        test_mismatch();
        test_encrypt();
        test_timeout();
        test_busy_defer();
        test_drop();
        test_reset_mid();
        test_back_to_back();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
